// File: rtl/transform_inverse_primary_if.sv
// Stream bundle for the inverse primary radix-2 stage:
// sum/diff words in, reconstructed samples out, sticky err.
interface transform_inverse_primary_if #(
  parameter int WIDTH = 16
) ();
  logic                 s_valid;
  logic                 s_ready;
  logic [2*WIDTH+1:0]   s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [2*WIDTH-1:0]   m_data;
  logic                 err;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, err
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, err
  );
endinterface

// File: rtl/transform_inverse_primary.sv
// Inverse primary radix-2 stage: (sum, diff) pairs -> samples a, b.
// TRANSFORM_INVERSE_SAT_EN selects saturation instead of wrap.
module transform_inverse_primary #(
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  transform_inverse_primary_if.slave    bus
);
  localparam int CW = WIDTH + 1;
  localparam int XW = WIDTH + 2;

  typedef enum logic {
    WAIT_SUM,
    WAIT_DIF
  } in_state_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_A,
    EMIT_B
  } out_state_t;

  in_state_t         in_state;
  out_state_t        out_state;
  logic [2*CW-1:0]   sum_r;
  logic [2*WIDTH-1:0] a_r;
  logic [2*WIDTH-1:0] b_r;
  logic              err_r;

  logic              load_ok;
  logic              s_fire;
  logic              load;
  logic              odd;
  logic [CW-1:0]     s_re, s_im, d_re, d_im;
  logic [XW-1:0]     sd_re, sd_im, df_re, df_im;
  logic [WIDTH-1:0]  a_re, a_im, b_re, b_im;

  function automatic logic [WIDTH-1:0] fit(
    input logic [CW-1:0] x
  );
`ifdef TRANSFORM_INVERSE_SAT_EN
    if (x[CW-1] != x[CW-2])
      fit = x[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                    : {1'b0, {(WIDTH-1){1'b1}}};
    else
      fit = x[WIDTH-1:0];
`else
    fit = x[WIDTH-1:0];
`endif
  endfunction

  assign s_re = sum_r[2*CW-1:CW];
  assign s_im = sum_r[CW-1:0];
  assign d_re = bus.s_data[2*CW-1:CW];
  assign d_im = bus.s_data[CW-1:0];

  // Sign-extend one bit so s+d and s-d never overflow.
  assign sd_re = {s_re[CW-1], s_re} + {d_re[CW-1], d_re};
  assign sd_im = {s_im[CW-1], s_im} + {d_im[CW-1], d_im};
  assign df_re = {s_re[CW-1], s_re} - {d_re[CW-1], d_re};
  assign df_im = {s_im[CW-1], s_im} - {d_im[CW-1], d_im};

  assign a_re = fit(sd_re[XW-1:1]);
  assign a_im = fit(sd_im[XW-1:1]);
  assign b_re = fit(df_re[XW-1:1]);
  assign b_im = fit(df_im[XW-1:1]);

  assign odd = sd_re[0] | sd_im[0] | df_re[0] | df_im[0];

  assign load_ok = (out_state == IDLE) ||
                   ((out_state == EMIT_B) && bus.m_ready);

  assign bus.s_ready = (in_state == WAIT_SUM) || load_ok;
  assign s_fire      = bus.s_valid && bus.s_ready;
  assign load        = s_fire && (in_state == WAIT_DIF);

  assign bus.m_valid = (out_state != IDLE);
  assign bus.m_data  = (out_state == EMIT_B) ? b_r : a_r;
  assign bus.err     = err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state  <= WAIT_SUM;
      out_state <= IDLE;
      sum_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      err_r     <= 1'b0;
    end else begin
      if (s_fire) begin
        unique case (in_state)
          WAIT_SUM: begin
            sum_r    <= bus.s_data;
            in_state <= WAIT_DIF;
          end
          WAIT_DIF: begin
            a_r      <= {a_im, a_re};
            b_r      <= {b_im, b_re};
            err_r    <= err_r | odd;
            in_state <= WAIT_SUM;
          end
          default: in_state <= WAIT_SUM;
        endcase
      end

      // A new pair loads on the b handshake, so pairs stream bubble-free.
      if (load) begin
        out_state <= EMIT_A;
      end else begin
        unique case (out_state)
          IDLE:    out_state <= IDLE;
          EMIT_A:  if (bus.m_ready) out_state <= EMIT_B;
          EMIT_B:  if (bus.m_ready) out_state <= IDLE;
          default: out_state <= IDLE;
        endcase
      end
    end
  end
endmodule
